// File: rtl/uart_transmitter_controller_pkg.sv
// Shared system-controller definitions for the transmit side.
//   DATA_WIDTH_DEF : default UART payload / register-file word width
//   tx_state_e     : transmit FSM state encoding
package uart_transmitter_controller_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    SEND_READ    = 2'b01,
    SEND_ALU_LSB = 2'b10,
    SEND_ALU_MSB = 2'b11
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_controller_request_buffer.sv
// Single-entry request slot: captures a valid payload, holds it with a
// pending flag until the consumer clears it, and flags a drop when a new
// valid arrives while the slot is still occupied.
// Ports:
//   clk, reset    : clock, async active-high reset
//   valid, data_in: single-cycle request and its payload
//   clear         : consumer has finished with the held payload
//   pending, hold : slot occupied flag and held payload
//   drop          : combinational, request arriving now is being discarded
module uart_tx_request_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] data_in,
  input  logic         clear,
  output logic         pending,
  output logic [W-1:0] hold,
  output logic         drop
);

  logic         pending_q, pending_d;
  logic [W-1:0] hold_q, hold_d;
  logic         capture;

  // A slot being freed this edge can take a new payload on the same edge.
  assign capture = valid && (!pending_q || clear);
  assign drop    = valid && pending_q && !clear;

  always_comb begin
    pending_d = pending_q;
    hold_d    = hold_q;
    if (clear)   pending_d = 1'b0;
    if (capture) begin
      pending_d = 1'b1;
      hold_d    = data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  assign pending = pending_q;
  assign hold    = hold_q;

endmodule

// File: rtl/uart_transmitter_controller.sv
// Transmit-side controller: arbitrates register-file read data (one byte)
// and ALU results (two bytes, LSB first) onto the TX FIFO write port,
// stalling on fifo_full.
// Ports:
//   clk, reset                       : clock, async active-high reset
//   enable                           : permits new transmit sequences
//   read_data / read_data_valid      : register-file response
//   ALU_result / ALU_result_valid    : ALU response (2*DATA_WIDTH)
//   fifo_full                        : TX FIFO full, synchronous to clk
//   fifo_write_enable / _data        : FIFO push strobe and byte
//   busy                             : work pending or in progress
//   overflow                         : one-cycle pulse on dropped request
module uart_transmitter_controller
  import uart_transmitter_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_data_valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_result,
  input  logic                    ALU_result_valid,
  input  logic                    fifo_full,
  output logic                    fifo_write_enable,
  output logic [DATA_WIDTH-1:0]   fifo_write_data,
  output logic                    busy,
  output logic                    overflow
);

  tx_state_e state_q, state_d;
  logic      overflow_q, overflow_d;

  logic                    read_pending, alu_pending;
  logic [DATA_WIDTH-1:0]   read_hold;
  logic [2*DATA_WIDTH-1:0] alu_hold;
  logic                    read_drop, alu_drop;
  logic                    read_clr, alu_clr;

  uart_tx_request_buffer #(.W(DATA_WIDTH)) u_read_buf (
    .clk     (clk),
    .reset   (reset),
    .valid   (read_data_valid),
    .data_in (read_data),
    .clear   (read_clr),
    .pending (read_pending),
    .hold    (read_hold),
    .drop    (read_drop)
  );

  uart_tx_request_buffer #(.W(2*DATA_WIDTH)) u_alu_buf (
    .clk     (clk),
    .reset   (reset),
    .valid   (ALU_result_valid),
    .data_in (ALU_result),
    .clear   (alu_clr),
    .pending (alu_pending),
    .hold    (alu_hold),
    .drop    (alu_drop)
  );

  assign fifo_write_enable = (state_q != IDLE) && !fifo_full;

  always_comb begin
    state_d         = state_q;
    fifo_write_data = '0;
    read_clr        = 1'b0;
    alu_clr         = 1'b0;
    case (state_q)
      IDLE: begin
        // Read data has fixed priority over the ALU result.
        if (enable && read_pending)     state_d = SEND_READ;
        else if (enable && alu_pending) state_d = SEND_ALU_LSB;
      end
      SEND_READ: begin
        fifo_write_data = read_hold;
        if (fifo_write_enable) begin
          read_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      SEND_ALU_LSB: begin
        fifo_write_data = alu_hold[DATA_WIDTH-1:0];
        if (fifo_write_enable) state_d = SEND_ALU_MSB;
      end
      SEND_ALU_MSB: begin
        fifo_write_data = alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
        if (fifo_write_enable) begin
          alu_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous drops from both sources merge into one pulse.
  assign overflow_d = read_drop | alu_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = read_pending | alu_pending | (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_transmitter_controller.sv
module tb_uart_transmitter_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  read_data;
  logic        read_data_valid;
  logic [15:0] ALU_result;
  logic        ALU_result_valid;
  logic        fifo_full;
  logic        fifo_write_enable;
  logic [7:0]  fifo_write_data;
  logic        busy;
  logic        overflow;

  uart_transmitter_controller #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .read_data        (read_data),
    .read_data_valid  (read_data_valid),
    .ALU_result       (ALU_result),
    .ALU_result_valid (ALU_result_valid),
    .fifo_full        (fifo_full),
    .fifo_write_enable(fifo_write_enable),
    .fifo_write_data  (fifo_write_data),
    .busy             (busy),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so at negedge the strobe seen
  // is the one the next posedge (edge number cyc+1) will accept.
  logic [7:0] wq[$];
  int         eq[$];
  always @(negedge clk) begin
    if (fifo_write_enable) begin
      wq.push_back(fifo_write_data);
      eq.push_back(cyc + 1);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses the selected valids for one cycle; k is the sampling edge.
  task automatic pulse(input logic rv, input logic [7:0] rd,
                       input logic av, input logic [15:0] ad, output int k);
    @(posedge clk); #1;
    read_data_valid  = rv; read_data  = rd;
    ALU_result_valid = av; ALU_result = ad;
    @(posedge clk); #1;
    k = cyc;
    read_data_valid  = 1'b0;
    ALU_result_valid = 1'b0;
  endtask

  task automatic clr_q();
    wq.delete();
    eq.delete();
  endtask

  int k, j;

  initial begin
    reset = 1'b1; enable = 1'b1; fifo_full = 1'b0;
    read_data = '0; read_data_valid = 1'b0;
    ALU_result = '0; ALU_result_valid = 1'b0;
    #2;
    chk("rst_wen",  fifo_write_enable, 0);
    chk("rst_data", fifo_write_data,   0);
    chk("rst_busy", busy,              0);
    chk("rst_ovf",  overflow,          0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);

    // 1: async reset while stalled in SEND_ALU_MSB
    clr_q();
    pulse(0, 8'h00, 1, 16'h1234, k);
    wait_cyc(2);             // just after edge k+2 (LSB accepted)
    fifo_full = 1'b1;
    chk("t1_lsb_cnt", wq.size(), 1);
    chk("t1_lsb",     (wq.size() > 0) ? wq[0] : 8'hxx, 8'h34);
    chk("t1_msb_hold", fifo_write_data, 8'h12);
    chk("t1_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_wen",  fifo_write_enable, 0);
    chk("t1_data", fifo_write_data,   0);
    chk("t1_busy", busy,              0);
    chk("t1_ovf",  overflow,          0);
    clr_q();
    wait_cyc(1);
    reset = 1'b0; fifo_full = 1'b0;
    wait_cyc(4);
    chk("t1_nowr",   wq.size(), 0);
    chk("t1_busy_post", busy, 0);

    // 2: single read byte
    clr_q();
    pulse(1, 8'hA5, 0, 16'h0, k);
    chk("t2_busy_act", busy, 1);
    wait_cyc(5);
    chk("t2_cnt",  wq.size(), 1);
    chk("t2_data", (wq.size() > 0) ? wq[0] : 8'hxx, 8'hA5);
    chk("t2_edge", (eq.size() > 0) ? eq[0] : -1, k + 2);
    chk("t2_busy", busy, 0);

    // 3: ALU result, two bytes LSB first
    clr_q();
    pulse(0, 8'h00, 1, 16'h12C4, k);
    wait_cyc(6);
    chk("t3_cnt", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t3_d0", wq[0], 8'hC4);
      chk("t3_e0", eq[0], k + 2);
      chk("t3_d1", wq[1], 8'h12);
      chk("t3_e1", eq[1], k + 3);
    end
    chk("t3_busy", busy, 0);

    // 4: both requesters in the same cycle
    clr_q();
    pulse(1, 8'h3C, 1, 16'hBEEF, k);
    wait_cyc(8);
    chk("t4_cnt", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("t4_d0", wq[0], 8'h3C);  chk("t4_e0", eq[0], k + 2);
      chk("t4_d1", wq[1], 8'hEF);  chk("t4_e1", eq[1], k + 4);
      chk("t4_d2", wq[2], 8'hBE);  chk("t4_e2", eq[2], k + 5);
    end

    // 5: 5-cycle stall after LSB acceptance
    clr_q();
    pulse(0, 8'h00, 1, 16'h0102, k);
    wait_cyc(2);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_wen",  fifo_write_enable, 0);
      chk("t5_stall_data", fifo_write_data,   8'h01);
      wait_cyc(1);
    end
    fifo_full = 1'b0;
    wait_cyc(4);
    chk("t5_cnt", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t5_d0", wq[0], 8'h02);  chk("t5_e0", eq[0], k + 2);
      chk("t5_d1", wq[1], 8'h01);  chk("t5_e1", eq[1], k + 8);
    end

    // 6a: drop while stalled
    clr_q();
    fifo_full = 1'b1;
    pulse(1, 8'h55, 0, 16'h0, k);
    wait_cyc(2);
    chk("t6_ovf_quiet", overflow, 0);
    pulse(1, 8'h77, 0, 16'h0, j);
    chk("t6_ovf_pulse", overflow, 1);
    wait_cyc(1);
    chk("t6_ovf_end", overflow, 0);
    chk("t6_data_held", fifo_write_data, 8'h55);
    fifo_full = 1'b0;
    wait_cyc(4);
    chk("t6_cnt", wq.size(), 1);
    chk("t6_data", (wq.size() > 0) ? wq[0] : 8'hxx, 8'h55);
    chk("t6_busy", busy, 0);

    // 6b: enable low - capture without writing, one merged overflow
    clr_q();
    enable = 1'b0;
    pulse(1, 8'h66, 1, 16'h0ABC, k);
    wait_cyc(2);
    pulse(1, 8'h99, 1, 16'hFFFF, j);
    chk("t6b_ovf_pulse", overflow, 1);
    wait_cyc(1);
    chk("t6b_ovf_end", overflow, 0);
    wait_cyc(3);
    chk("t6b_nowr", wq.size(), 0);
    chk("t6b_busy", busy, 1);
    enable = 1'b1;
    wait_cyc(8);
    chk("t6b_cnt", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("t6b_d0", wq[0], 8'h66);
      chk("t6b_d1", wq[1], 8'hBC);
      chk("t6b_d2", wq[2], 8'h0A);
    end
    chk("t6b_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_controller.md
Name: uart_transmitter_controller

Overview:
- Transmit-side half of the system controller. Collects responses from two requesters and serialises them as bytes into the TX clock-domain-crossing FIFO feeding the UART transmitter.
- Requester 1: register-file read data, one byte.
- Requester 2: ALU result, 2*DATA_WIDTH bits, sent as two bytes, LSB first.
- The block arbitrates the single FIFO write port between the two requesters and absorbs FIFO back-pressure.

Parameters:
- DATA_WIDTH, 8, width of one UART frame payload / register-file word; ALU result is 2*DATA_WIDTH.

Ports:
- clk  in  1  reference clock (40 MHz system domain)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  allows new transmit sequences to start
- read_data  in  DATA_WIDTH  register-file read data
- read_data_valid  in  1  single-cycle qualifier for read_data
- ALU_result  in  2*DATA_WIDTH  ALU output
- ALU_result_valid  in  1  single-cycle qualifier for ALU_result
- fifo_full  in  1  TX FIFO full flag, already synchronised to clk
- fifo_write_enable  out  1  FIFO push strobe
- fifo_write_data  out  DATA_WIDTH  byte pushed into FIFO
- busy  out  1  high while any request is pending or in progress
- overflow  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high. Reset clears all registers: state=IDLE, pending flags=0, holding registers=0, overflow=0. Outputs are then 0.
- Capture, each edge:
  - read_data_valid=1 with read_pending=0: latch read_data into read_hold and set read_pending.
  - ALU_result_valid=1 with alu_pending=0: latch ALU_result into alu_hold and set alu_pending.
  - Capture happens regardless of enable.
- Drop:
  - A valid arriving while its own pending flag is set is dropped; the hold register is unchanged.
  - overflow is registered high for exactly the next cycle.
  - Both sources dropping in the same cycle produces a single overflow pulse.
- FSM states: IDLE, SEND_READ, SEND_ALU_LSB, SEND_ALU_MSB.
  - IDLE: if enable=1 and read_pending=1, go to SEND_READ. Else if enable=1 and alu_pending=1, go to SEND_ALU_LSB. Otherwise stay. Read data has fixed priority when both are pending.
  - SEND_READ: fifo_write_data=read_hold. On an accepted write, clear read_pending and go to IDLE.
  - SEND_ALU_LSB: fifo_write_data=alu_hold[DATA_WIDTH-1:0]. On an accepted write, go to SEND_ALU_MSB.
  - SEND_ALU_MSB: fifo_write_data=alu_hold[2*DATA_WIDTH-1:DATA_WIDTH]. On an accepted write, clear alu_pending and go to IDLE.
- Write acceptance:
  - fifo_write_enable = (state != IDLE) and !fifo_full. This is combinational from state and fifo_full.
  - A write is accepted at an edge where fifo_write_enable=1.
  - fifo_full=1 stalls the FSM in its current SEND state; data is held stable.
  - In IDLE, fifo_write_data=0.
- Latency:
  - valid sampled at edge k: pending is set at k, the FSM enters SEND at k+1, and the first byte is written at k+2 if the FIFO is not full.
  - ALU MSB is written at k+3.
  - Minimum spacing between consecutive sequences is 1 IDLE cycle.
- Simultaneous events:
  - A valid for a source may be captured in the same edge that clears that source's pending flag. The new capture wins: the flag stays set and the hold register is loaded.
  - Both valids in the same cycle: read byte first, then ALU LSB and ALU MSB. Writes occur at k+2, k+4, k+5 with the FIFO not full.
- enable deasserted mid-sequence: the current sequence completes, both ALU bytes included. No new sequence starts.
- reset mid-sequence: the sequence is abandoned immediately. An ALU MSB may be lost after its LSB was pushed; this is accepted.
- busy = read_pending | alu_pending | (state != IDLE).

Decomposition:
- Shared system-controller package holds:
  - state encoding localparams: IDLE=2'b00, SEND_READ=2'b01, SEND_ALU_LSB=2'b10, SEND_ALU_MSB=2'b11;
  - DATA_WIDTH default.
- Natural sub-module: uart_tx_request_buffer. This is a single-entry capture/pending/overflow slot, parameterised by width and instantiated twice: DATA_WIDTH and 2*DATA_WIDTH.
- The FSM and output mux live in the top module.

Test Plan:
1. Reset asserted mid-SEND_ALU_MSB with fifo_full=1 -> all outputs 0 immediately (asynchronous). After release, busy=0 and no write occurs.
2. read_data=0xA5 pulse, enable=1, fifo_full=0 -> exactly one write, fifo_write_data=0xA5, 2 edges after the valid edge; busy returns to 0.
3. ALU_result=0x12C4 pulse -> writes 0xC4 then 0x12 on consecutive edges k+2, k+3; no other writes.
4. read_data=0x3C and ALU_result=0xBEEF pulsed in the same cycle -> write order 0x3C, 0xEF, 0xBE.
5. ALU_result=0x0102 with fifo_full held high for 5 cycles after LSB acceptance -> fifo_write_data holds 0x01 with enable low during stall. 0x01 is written on the first edge with fifo_full=0.
6. Second read_data_valid (0x77) while the first (0x55) is stalled by fifo_full -> overflow pulses 1 cycle; only 0x55 is written. Repeat with enable=0: captures occur, no writes until enable=1.
